// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the physical-memory port between I-cache and D-cache misses.
// Data side wins ties; one memory transaction in flight; one IDLE cycle between services.
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_read,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic [LINE_WIDTH-1:0] inst_rdata,
   output logic                  inst_resp,
   input  logic                  data_read,
   input  logic                  data_write,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [LINE_WIDTH-1:0] data_wdata,
   output logic [LINE_WIDTH-1:0] data_rdata,
   output logic                  data_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_INST,
      SERVE_DATA
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [LINE_WIDTH-1:0] lat_wdata;
   logic                  lat_write;
   logic                  data_req;

   assign data_req   = data_read | data_write;
   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

   // State register; the granted request is captured only while IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            if (data_req) begin
               lat_addr  <= data_addr;
               lat_wdata <= data_wdata;
               lat_write <= data_write;
            end else if (inst_read) begin
               lat_addr  <= inst_addr;
               lat_write <= 1'b0;
            end
         end
      end
   end

   // Grant decision, memory drive from the latch, same-cycle completion pulses
   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      inst_resp = 1'b0;
      data_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (data_req) begin
               state_nxt = SERVE_DATA;
            end else if (inst_read) begin
               state_nxt = SERVE_INST;
            end
         end
         SERVE_INST: begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_write = lat_write;
            mem_read  = ~lat_write;
            if (mem_resp) begin
               inst_resp = 1'b1;
               state_nxt = IDLE;
            end
         end
         SERVE_DATA: begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_write = lat_write;
            mem_read  = ~lat_write;
            if (mem_resp) begin
               data_resp = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter.
module tb_cache_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          inst_read;
   logic [AW-1:0] inst_addr;
   logic [LW-1:0] inst_rdata;
   logic          inst_resp;
   logic          data_read;
   logic          data_write;
   logic [AW-1:0] data_addr;
   logic [LW-1:0] data_wdata;
   logic [LW-1:0] data_rdata;
   logic          data_resp;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [LW-1:0] LINE_A = {8{32'hAAAA_AAAA}};
   localparam logic [LW-1:0] LINE_5 = {8{32'h5555_5555}};

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .inst_read(inst_read), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_resp(inst_resp),
      .data_read(data_read), .data_write(data_write),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_resp(data_resp),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_read  = 1'b0;
      inst_addr  = '0;
      data_read  = 1'b0;
      data_write = 1'b0;
      data_addr  = '0;
      data_wdata = '0;
      mem_rdata  = '0;
      mem_resp   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      mem_resp = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         mem_resp = (c != 1);
         @(negedge clk);
         n_tests++;
         if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl c%0d: got %b want 0000", c,
                     {mem_read, mem_write, inst_resp, data_resp});
         end
         n_tests++;
         if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus c%0d: got addr %h wdata %h want 0", c,
                     mem_addr, mem_wdata);
         end
         next_cycle();
      end
      mem_resp = 1'b0;
   endtask

   task automatic test_inst_read();
      int pulses = 0;
      inst_read = 1'b1;
      inst_addr = 32'h0000_1000;
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b0) begin
         n_fail++;
         $display("FAIL inst_latency0: got mem_read %b want 0", mem_read);
      end
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         mem_resp  = (c == 2);
         mem_rdata = (c == 2) ? LINE_A : '0;
         @(negedge clk);
         n_tests++;
         if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h1000) begin
            n_fail++;
            $display("FAIL inst_drive c%0d: got rd %b wr %b addr %h want 1 0 1000",
                     c, mem_read, mem_write, mem_addr);
         end
         pulses += int'(inst_resp);
         n_tests++;
         if (data_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL inst_no_dresp c%0d: got %b want 0", c, data_resp);
         end
      end
      n_tests++;
      if (inst_resp !== 1'b1 || inst_rdata !== LINE_A) begin
         n_fail++;
         $display("FAIL inst_resp: got %b %h want 1 %h", inst_resp, inst_rdata, LINE_A);
      end
      next_cycle();
      inst_read = 1'b0;
      mem_resp  = 1'b0;
      @(negedge clk);
      pulses += int'(inst_resp);
      n_tests++;
      if (pulses != 1 || mem_read !== 1'b0) begin
         n_fail++;
         $display("FAIL inst_single: got %0d pulses rd %b want 1 pulse rd 0",
                  pulses, mem_read);
      end
      next_cycle();
   endtask

   task automatic test_priority();
      inst_read = 1'b1;
      inst_addr = 32'h1000;
      data_read = 1'b1;
      data_addr = 32'h2000;
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b1 || mem_addr !== 32'h2000) begin
         n_fail++;
         $display("FAIL prio_data_first: got rd %b addr %h want 1 2000", mem_read, mem_addr);
      end
      next_cycle();
      mem_resp = 1'b1;
      @(negedge clk);
      n_tests++;
      if (data_resp !== 1'b1 || inst_resp !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_dresp: got d %b i %b want 1 0", data_resp, inst_resp);
      end
      next_cycle();
      data_read = 1'b0;
      mem_resp  = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b0 || inst_resp !== 1'b0 || data_resp !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_idle_gap: got rd %b i %b d %b want 0 0 0",
                  mem_read, inst_resp, data_resp);
      end
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b1 || mem_addr !== 32'h1000) begin
         n_fail++;
         $display("FAIL prio_inst_next: got rd %b addr %h want 1 1000", mem_read, mem_addr);
      end
      next_cycle();
      mem_resp = 1'b1;
      @(negedge clk);
      n_tests++;
      if (inst_resp !== 1'b1 || data_resp !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_iresp: got i %b d %b want 1 0", inst_resp, data_resp);
      end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_write();
      int pulses = 0;
      data_write = 1'b1;
      data_addr  = 32'h3000;
      data_wdata = LINE_5;
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            data_addr  = 32'h4000;
            data_wdata = rand_line();
         end
         mem_resp = (c == 2);
         @(negedge clk);
         n_tests++;
         if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h3000 ||
             mem_wdata !== LINE_5) begin
            n_fail++;
            $display("FAIL write_hold c%0d: got wr %b rd %b addr %h wdata %h", c,
                     mem_write, mem_read, mem_addr, mem_wdata);
         end
         pulses += int'(data_resp);
         next_cycle();
      end
      data_write = 1'b0;
      mem_resp   = 1'b0;
      @(negedge clk);
      pulses += int'(data_resp);
      n_tests++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL write_single_resp: got %0d want 1", pulses);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      inst_read = 1'b1;
      inst_addr = 32'h1000;
      next_cycle();
      mem_resp = 1'b1;
      @(negedge clk);
      pulses += int'(inst_resp);
      next_cycle();
      inst_addr = 32'h5000;
      mem_resp  = 1'b0;
      @(negedge clk);
      pulses += int'(inst_resp);
      n_tests++;
      if (pulses != 1 || mem_read !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_first: got %0d pulses rd %b want 1 pulse rd 0",
                  pulses, mem_read);
      end
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b1 || mem_addr !== 32'h5000 || inst_resp !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: got rd %b addr %h resp %b want 1 5000 0",
                  mem_read, mem_addr, inst_resp);
      end
      next_cycle();
      mem_resp = 1'b1;
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_rst_mid();
      inst_read = 1'b1;
      inst_addr = 32'h7000;
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_start: got rd %b want 1", mem_read);
      end
      next_cycle();
      rst       = 1'b1;
      inst_read = 1'b0;
      next_cycle();
      rst      = 1'b0;
      mem_resp = 1'b1;
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b0 || inst_resp !== 1'b0 || data_resp !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_drop: got rd %b i %b d %b want 0 0 0",
                  mem_read, inst_resp, data_resp);
      end
      next_cycle();
      mem_resp = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: got rd %b wr %b want 0 0", mem_read, mem_write);
      end
      next_cycle();
   endtask

   task automatic test_random();
      bit            busy  = 1'b0;
      bit            is_d  = 1'b0;
      bit            wr    = 1'b0;
      logic [AW-1:0] addr  = '0;
      logic [LW-1:0] wline = '0;
      bit            ireq  = 1'b0;
      bit            dreq  = 1'b0;
      int            dkind = 0;
      bit            prev_resp = 1'b0;
      bit            e_ir, e_dr, e_mr, e_mw;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wdata;
      for (int c = 0; c < 3000; c++) begin
         rst        = (c == 0) || ($urandom_range(0, 199) == 0);
         inst_read  = ireq;
         inst_addr  = $urandom;
         data_read  = dreq && (dkind != 1);
         data_write = dreq && (dkind != 0);
         data_addr  = $urandom;
         data_wdata = rand_line();
         mem_resp   = ($urandom_range(0, 2) == 0);
         mem_rdata  = rand_line();

         e_mr    = busy && !wr;
         e_mw    = busy && wr;
         e_addr  = busy ? addr : '0;
         e_wdata = busy ? wline : '0;
         e_ir    = busy && !is_d && mem_resp;
         e_dr    = busy && is_d && mem_resp;

         @(negedge clk);
         n_tests++;
         if ({inst_resp, data_resp, mem_read, mem_write} !== {e_ir, e_dr, e_mr, e_mw} ||
             mem_addr !== e_addr || mem_wdata !== e_wdata ||
             inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
            n_fail++;
            $display("FAIL rand c%0d: got ir%b dr%b rd%b wr%b a%h want ir%b dr%b rd%b wr%b a%h",
                     c, inst_resp, data_resp, mem_read, mem_write, mem_addr,
                     e_ir, e_dr, e_mr, e_mw, e_addr);
         end
         n_tests++;
         if (prev_resp && (inst_resp || data_resp)) begin
            n_fail++;
            $display("FAIL rand_consec c%0d: got resp two cycles in a row want gap", c);
         end
         prev_resp = inst_resp | data_resp;

         if (rst) begin
            busy  = 1'b0;
            wline = '0;
         end else if (busy) begin
            if (mem_resp) busy = 1'b0;
         end else if (data_read || data_write) begin
            busy  = 1'b1;
            is_d  = 1'b1;
            wr    = data_write;
            addr  = data_addr;
            wline = data_wdata;
         end else if (inst_read) begin
            busy = 1'b1;
            is_d = 1'b0;
            wr   = 1'b0;
            addr = inst_addr;
         end

         if (e_ir) ireq = ($urandom_range(0, 1) == 0);
         else if (!ireq) ireq = ($urandom_range(0, 2) == 0);
         if (e_dr || !dreq) begin
            dreq = e_dr ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
            dkind = $urandom_range(0, 19);
            dkind = (dkind == 0) ? 2 : (dkind < 10) ? 0 : 1;
         end
         next_cycle();
      end
      rst = 1'b0;
      clear_inputs();
      next_cycle();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_inst_read();
      test_priority();
      test_write();
      test_back_to_back();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
